hb_decimate_round: RTL and testbench



---
 rtl/hbdec_pkg.sv | 21 ++
 rtl/hbdec_fifo.sv | 62 ++++++
 rtl/hb_decimate_round.sv | 115 +++++++++++
 tb/tb_hb_decimate_round.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/hbdec_pkg.sv
// Shared widths, saturation limits and rounding helper for the half-band decimator.
package hbdec_pkg;

  localparam int unsigned DEF_IW     = 35;
  localparam int unsigned DEF_OW     = 16;
  localparam int unsigned DEF_SHIFT  = 11;
  localparam int unsigned DEF_LGFIFO = 2;

  // Saturation limits at the default output width.
  localparam logic [DEF_OW-1:0] OUT_MAX = {1'b0, {(DEF_OW-1){1'b1}}};
  localparam logic [DEF_OW-1:0] OUT_MIN = {1'b1, {(DEF_OW-1){1'b0}}};

  // Half-LSB-minus-one bias; the discarded-LSB parity bit is added separately to round half to even.
  function automatic logic [63:0] round_const(input int unsigned shift);
    logic [63:0] k;
    k = 64'd0;
    if (shift != 0) k = (64'd1 << (shift - 1)) - 64'd1;
    return k;
  endfunction

endpackage

// File: rtl/hbdec_fifo.sv
// Synchronous FIFO with a registered head word. Pointers are one bit wider than the address, so full and empty are told apart by the pointer MSBs.
module hbdec_fifo #(
  parameter int unsigned W  = 16,
  parameter int unsigned LG = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data,
  output logic         rd_valid,
  output logic         full_c,
  output logic         empty_c
);

  localparam int unsigned DEPTH = 1 << LG;

  logic [W-1:0] mem [DEPTH];
  logic [LG:0]  wr_ptr;
  logic [LG:0]  rd_ptr;
  logic [LG:0]  rd_next_c;
  logic         do_push_c;
  logic         do_pop_c;

  // Occupancy flags and the read pointer after this cycle's pop.
  always_comb begin
    empty_c   = (wr_ptr == rd_ptr);
    full_c    = (wr_ptr[LG] != rd_ptr[LG]) && (wr_ptr[LG-1:0] == rd_ptr[LG-1:0]);
    do_pop_c  = pop & ~empty_c;
    do_push_c = push & (~full_c | do_pop_c);
    rd_next_c = rd_ptr + (LG+1)'(do_pop_c);
  end

  // Storage array; the contents need no reset because the pointers guard them.
  always_ff @(posedge clk) begin
    if (do_push_c) mem[wr_ptr[LG-1:0]] <= wr_data;
  end

  // Pointers advance on accepted pushes and pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + (LG+1)'(1);
      rd_ptr <= rd_next_c;
    end
  end

  // The head register looks one pop ahead, so back-to-back pops stream; it holds its value while the FIFO is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= (wr_ptr != rd_next_c);
      if (wr_ptr != rd_next_c) rd_data <= mem[rd_next_c[LG-1:0]];
    end
  end

endmodule

// File: rtl/hb_decimate_round.sv
// Decimate-by-2, round-half-even and saturate the half-band filter output, then buffer it for a valid/ready consumer.
// Optional feature: define HBDEC_DROPCOUNT_EN to add the o_drop_count port.
module hb_decimate_round
  import hbdec_pkg::*;
#(
  parameter int unsigned IW     = DEF_IW,
  parameter int unsigned OW     = DEF_OW,
  parameter int unsigned SHIFT  = DEF_SHIFT,
  parameter int unsigned LGFIFO = DEF_LGFIFO
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_ce,
  input  logic [IW-1:0] i_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [OW-1:0] o_data,
  output logic          o_overflow,
  output logic          o_clipped
`ifdef HBDEC_DROPCOUNT_EN
  ,
  output logic [15:0]   o_drop_count
`endif
);

  localparam int unsigned RW = IW + 1 - SHIFT;
  localparam logic [IW:0] RND_K = (IW+1)'(round_const(SHIFT));
  localparam logic [OW-1:0] SAT_MAX = {1'b0, {(OW-1){1'b1}}};
  localparam logic [OW-1:0] SAT_MIN = {1'b1, {(OW-1){1'b0}}};

  logic          phase;
  logic          keep_c;
  logic [IW:0]   data_ext_c;
  logic [IW:0]   sum_c;
  logic [RW-1:0] rnd_c;
  logic [RW-1:0] r_rnd;
  logic          r1_valid;
  logic [RW-OW:0] top_c;
  logic          clip_c;
  logic [OW-1:0] sat_c;
  logic          full_c;
  logic          empty_c;
  logic          pop_c;
  logic          drop_c;

  // Convergent rounding: bias by half-minus-one plus the parity of the lowest kept bit.
  always_comb begin
    keep_c     = i_ce & ~phase;
    data_ext_c = {i_data[IW-1], i_data};
    sum_c      = data_ext_c;
    if (SHIFT != 0) sum_c = data_ext_c + RND_K + (IW+1)'(i_data[SHIFT % IW]);
    rnd_c      = RW'($signed(sum_c) >>> SHIFT);
  end

  // Decimation phase and stage-1 rounding register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      phase    <= 1'b0;
      r1_valid <= 1'b0;
      r_rnd    <= '0;
    end else begin
      r1_valid <= keep_c;
      if (i_ce) phase <= ~phase;
      if (keep_c) r_rnd <= rnd_c;
    end
  end

  // Stage 2: clamp when the bits above the output sign do not all match it.
  always_comb begin
    top_c  = r_rnd[RW-1:OW-1];
    clip_c = ~((&top_c) | ~(|top_c));
    sat_c  = r_rnd[OW-1:0];
    if (clip_c) sat_c = r_rnd[RW-1] ? SAT_MIN : SAT_MAX;
    pop_c  = o_valid & i_ready & ~empty_c;
    drop_c = r1_valid & full_c & ~pop_c;
  end

  hbdec_fifo #(
    .W  (OW),
    .LG (LGFIFO)
  ) u_fifo (
    .clk      (i_clk),
    .rst_n    (i_reset_n),
    .push     (r1_valid),
    .pop      (pop_c),
    .wr_data  (sat_c),
    .rd_data  (o_data),
    .rd_valid (o_valid),
    .full_c   (full_c),
    .empty_c  (empty_c)
  );

  // Clip pulse aligned with the push, and the sticky loss flag.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_clipped  <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_clipped <= r1_valid & clip_c;
      if (drop_c) o_overflow <= 1'b1;
    end
  end

`ifdef HBDEC_DROPCOUNT_EN
  // Saturating count of discarded pushes.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_drop_count <= 16'd0;
    end else if (drop_c && (o_drop_count != 16'hFFFF)) begin
      o_drop_count <= o_drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hb_decimate_round.sv
// Directed bench for hb_decimate_round; expected words are hand-computed constants.
module tb_hb_decimate_round;

  localparam int unsigned IW = 35;
  localparam int unsigned OW = 16;

  logic          clk;
  logic          rst_n;
  logic          ce;
  logic [IW-1:0] data_in;
  logic          valid;
  logic          ready;
  logic [OW-1:0] data_out;
  logic          overflow;
  logic          clipped;
`ifdef HBDEC_DROPCOUNT_EN
  logic [15:0]   drop_count;
`endif

  int total = 0;
  int bad   = 0;
  bit tb_phase = 1'b0;

  hb_decimate_round dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_ce       (ce),
    .i_data     (data_in),
    .o_valid    (valid),
    .i_ready    (ready),
    .o_data     (data_out),
    .o_overflow (overflow),
    .o_clipped  (clipped)
`ifdef HBDEC_DROPCOUNT_EN
    ,
    .o_drop_count (drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One-cycle strobe; returns at the falling edge after the sampling edge.
  task automatic strobe(input longint d);
    ce = 1'b1;
    data_in = IW'(d);
    @(negedge clk);
    ce = 1'b0;
    data_in = 35'h2A5A5A5A5;
    tb_phase = ~tb_phase;
  endtask

  // Strobe with the FIFO empty and ready high; check latency, clip pulse and the word.
  task automatic send(input string tag, input longint d, input logic [15:0] exp, input logic exp_clip);
    bit kept;
    kept = ~tb_phase;
    strobe(d);
    @(negedge clk);
    check({tag, "_lat"}, 64'(valid), 64'd0);
    check({tag, "_clip"}, 64'(clipped), kept ? 64'(exp_clip) : 64'd0);
    @(negedge clk);
    check({tag, "_valid"}, 64'(valid), 64'(kept));
    if (kept) check({tag, "_data"}, 64'(data_out), 64'(exp));
    repeat (5) @(negedge clk);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tb_phase = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    ce = 1'b0;
    data_in = '0;
    ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_data", 64'(data_out), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_clip", 64'(clipped), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Decimation: k*0x800 for k=1..6 keeps 1,3,5.
    for (int k = 1; k <= 6; k++) send("dec", longint'(k) * 64'sh800, 16'(k), 1'b0);

    // Rounding at kept positions with large dummies between.
    send("rnd400", 64'sh400, 16'd0, 1'b0);
    send("dummy", 64'sh4000000, 16'd0, 1'b0);
    send("rndC00", 64'shC00, 16'd2, 1'b0);
    send("dummy", 64'sh4000000, 16'd0, 1'b0);
    send("rnd401", 64'sh401, 16'd1, 1'b0);
    send("dummy", 64'sh4000000, 16'd0, 1'b0);
    send("rnd3FF", 64'sh3FF, 16'd0, 1'b0);
    send("dummy", 64'sh4000000, 16'd0, 1'b0);
    send("rndm400", -64'sh400, 16'd0, 1'b0);
    send("dummy", 64'sh4000000, 16'd0, 1'b0);

    // Saturation.
    send("satpos", 64'sh4000000, 16'h7FFF, 1'b1);
    send("dummy", 64'sh1, 16'd0, 1'b0);
    send("satneg", -64'sh4000800, 16'h8000, 1'b1);
    send("dummy", 64'sh1, 16'd0, 1'b0);
    send("nosat", 64'sh3FFF800, 16'h7FFF, 1'b0);
    send("dummy", 64'sh1, 16'd0, 1'b0);
    check("ovf_before_bp", 64'(overflow), 64'd0);

    // Backpressure: five kept words into a four-deep FIFO.
    ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      strobe(longint'(k) * 64'sh800);
      strobe(64'sh0);
    end
    repeat (4) @(negedge clk);
    check("bp_valid", 64'(valid), 64'd1);
    check("bp_head", 64'(data_out), 64'd1);
    check("bp_ovf", 64'(overflow), 64'd1);
`ifdef HBDEC_DROPCOUNT_EN
    check("bp_dropcnt", 64'(drop_count), 64'd1);
`endif
    ready = 1'b1;
    for (int j = 2; j <= 4; j++) begin
      @(negedge clk);
      check("bp_drain_valid", 64'(valid), 64'd1);
      check("bp_drain_data", 64'(data_out), 64'(j));
    end
    @(negedge clk);
    check("bp_empty", 64'(valid), 64'd0);

    // Full FIFO with a simultaneous push and pop.
    reset_dut();
    ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      strobe(longint'(k) * 64'sh800);
      strobe(64'sh0);
    end
    repeat (3) @(negedge clk);
    check("full_head", 64'(data_out), 64'd1);
    strobe(64'sh2800);
    ready = 1'b1;
    check("full_pp_head", 64'(data_out), 64'd1);
    for (int j = 2; j <= 5; j++) begin
      @(negedge clk);
      check("full_pp_valid", 64'(valid), 64'd1);
      check("full_pp_data", 64'(data_out), 64'(j));
    end
    @(negedge clk);
    check("full_pp_empty", 64'(valid), 64'd0);
    check("full_pp_ovf", 64'(overflow), 64'd0);
`ifdef HBDEC_DROPCOUNT_EN
    check("full_pp_dropcnt", 64'(drop_count), 64'd0);
`endif

    // Asynchronous reset with words queued, phase left odd beforehand.
    ready = 1'b0;
    strobe(64'sh0);
    strobe(64'sh800);
    strobe(64'sh0);
    strobe(64'sh1000);
    repeat (3) @(negedge clk);
    check("ar_pre_valid", 64'(valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", 64'(valid), 64'd0);
    check("ar_data", 64'(data_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tb_phase = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    send("ar_first", 64'sh1800, 16'd3, 1'b0);
    check("ar_ovf", 64'(overflow), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
